// File: rtl/clock_scan.sv
// clock_scan: BCD event counter with a multiplexed seven-segment scan.
// A prescaler turns run-qualified clk cycles into count ticks. A free-running
// scan counter walks a one-hot digit select across the BCD digits.
// Optional macro CLOCK_SCAN_LZB_EN enables leading-zero blanking on sm_seg.
module clock_scan #(
    parameter int DIGITS   = 4,
    parameter int TICK_DIV = 1000,
    parameter int SCAN_DIV = 100
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  run,
    input  logic                  clear,
    output logic [DIGITS-1:0]     sm_bit,
    output logic [6:0]            sm_seg,
    output logic [4*DIGITS-1:0]   count_bcd,
    output logic                  wrap
);

    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);
    localparam logic [SW-1:0] SCAN_MAX  = SW'(SCAN_DIV - 1);
    localparam logic [IW-1:0] IDX_MAX   = IW'(DIGITS - 1);

    logic [PW-1:0]          presc_r;
    logic [SW-1:0]          scan_cnt_r;
    logic [IW-1:0]          digit_idx_r;
    logic [4*DIGITS-1:0]    count_bcd_r;
    logic                   wrap_r;
    logic [DIGITS-1:0]      sm_bit_r;
    logic [6:0]             sm_seg_r;

    logic                   tick_s;
    logic [4*DIGITS-1:0]    count_next_s;
    logic                   carry_s;
    logic [3:0]             sel_digit_s;
    logic [DIGITS-1:0]      bit_next_s;
    logic [6:0]             seg_next_s;
`ifdef CLOCK_SCAN_LZB_EN
    logic                   lead_zero_s;
    logic                   blank_sel_s;
`endif

    // BCD to active-high {a,b,c,d,e,f,g}; non-decimal codes go dark.
    function automatic logic [6:0] seg_decode(input logic [3:0] code);
        logic [6:0] seg;
        case (code)
            4'd0:    seg = 7'b1111110;
            4'd1:    seg = 7'b0110000;
            4'd2:    seg = 7'b1101101;
            4'd3:    seg = 7'b1111001;
            4'd4:    seg = 7'b0110011;
            4'd5:    seg = 7'b1011011;
            4'd6:    seg = 7'b1011111;
            4'd7:    seg = 7'b1110000;
            4'd8:    seg = 7'b1111111;
            4'd9:    seg = 7'b1111011;
            default: seg = 7'b0000000;
        endcase
        return seg;
    endfunction

    // Clear wins over run, so a clearing cycle can never also tick.
    assign tick_s = run && !clear && (presc_r == PRESC_MAX);

    // Prescaler: advances only while running, holds otherwise.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            presc_r <= {PW{1'b0}};
        end else if (clear) begin
            presc_r <= {PW{1'b0}};
        end else if (run) begin
            if (presc_r == PRESC_MAX) begin
                presc_r <= {PW{1'b0}};
            end else begin
                presc_r <= presc_r + PW'(1);
            end
        end
    end

    // Decimal ripple increment; carry out of the top digit means all nines.
    always_comb begin
        carry_s      = 1'b1;
        count_next_s = count_bcd_r;
        for (int i = 0; i < DIGITS; i++) begin
            if (carry_s) begin
                if (count_bcd_r[4*i +: 4] >= 4'd9) begin
                    count_next_s[4*i +: 4] = 4'd0;
                    carry_s                = 1'b1;
                end else begin
                    count_next_s[4*i +: 4] = count_bcd_r[4*i +: 4] + 4'd1;
                    carry_s                = 1'b0;
                end
            end else begin
                count_next_s[4*i +: 4] = count_bcd_r[4*i +: 4];
            end
        end
    end

    // Count register and one-cycle rollover pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_bcd_r <= {(4*DIGITS){1'b0}};
            wrap_r      <= 1'b0;
        end else if (clear) begin
            count_bcd_r <= {(4*DIGITS){1'b0}};
            wrap_r      <= 1'b0;
        end else if (tick_s) begin
            count_bcd_r <= count_next_s;
            wrap_r      <= carry_s;
        end else begin
            wrap_r      <= 1'b0;
        end
    end

    // Scan timing runs freely, independent of run and clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            scan_cnt_r  <= {SW{1'b0}};
            digit_idx_r <= {IW{1'b0}};
        end else if (scan_cnt_r == SCAN_MAX) begin
            scan_cnt_r <= {SW{1'b0}};
            if (digit_idx_r == IDX_MAX) begin
                digit_idx_r <= {IW{1'b0}};
            end else begin
                digit_idx_r <= digit_idx_r + IW'(1);
            end
        end else begin
            scan_cnt_r <= scan_cnt_r + SW'(1);
        end
    end

    // One-hot select and the digit it points at, from the same index.
    always_comb begin
        sel_digit_s = 4'd0;
        bit_next_s  = {DIGITS{1'b0}};
        for (int i = 0; i < DIGITS; i++) begin
            if (int'(digit_idx_r) == i) begin
                bit_next_s[i] = 1'b1;
                sel_digit_s   = count_bcd_r[4*i +: 4];
            end else begin
                bit_next_s[i] = 1'b0;
            end
        end
    end

    // Segment pattern for the selected digit, optionally blanking leading zeros.
    always_comb begin
        seg_next_s = seg_decode(sel_digit_s);
`ifdef CLOCK_SCAN_LZB_EN
        lead_zero_s = 1'b1;
        blank_sel_s = 1'b0;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            lead_zero_s = lead_zero_s && (count_bcd_r[4*i +: 4] == 4'd0);
            if ((i != 0) && lead_zero_s && (int'(digit_idx_r) == i)) begin
                blank_sel_s = 1'b1;
            end else begin
                blank_sel_s = blank_sel_s;
            end
        end
        if (blank_sel_s) begin
            seg_next_s = 7'b0000000;
        end else begin
            seg_next_s = seg_decode(sel_digit_s);
        end
`endif
    end

    // Display outputs registered together so select and segments stay aligned.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sm_bit_r <= {DIGITS{1'b0}};
            sm_seg_r <= 7'b0000000;
        end else begin
            sm_bit_r <= bit_next_s;
            sm_seg_r <= seg_next_s;
        end
    end

    assign sm_bit    = sm_bit_r;
    assign sm_seg    = sm_seg_r;
    assign count_bcd = count_bcd_r;
    assign wrap      = wrap_r;

endmodule

// File: tb/tb_clock_scan.sv
// Self-checking bench for clock_scan (DIGITS=2, TICK_DIV=4, SCAN_DIV=2).
// Reference model keeps the count as an integer 0..99 and derives digits
// and segment patterns arithmetically.
module tb_clock_scan;

    localparam int DIGITS   = 2;
    localparam int TICK_DIV = 4;
    localparam int SCAN_DIV = 2;

    logic       clk = 1'b0;
    logic       rst;
    logic       run;
    logic       clear;
    logic [1:0] sm_bit;
    logic [6:0] sm_seg;
    logic [7:0] count_bcd;
    logic       wrap;

    int checks = 0;
    int errors = 0;

    int   m_count, m_presc, m_scan, m_idx;
    logic m_wrap;

    logic [6:0] seg_tab [10];

    typedef struct {
        logic       run;
        logic       clear;
        logic [7:0] exp_count;
        logic       exp_wrap;
    } vec_t;
    vec_t vecs [15];

    always #5 clk = ~clk;

    clock_scan #(
        .DIGITS   (DIGITS),
        .TICK_DIV (TICK_DIV),
        .SCAN_DIV (SCAN_DIV)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .run       (run),
        .clear     (clear),
        .sm_bit    (sm_bit),
        .sm_seg    (sm_seg),
        .count_bcd (count_bcd),
        .wrap      (wrap)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] exp_bcd(input int cnt);
        return {4'(cnt / 10), 4'(cnt % 10)};
    endfunction

    function automatic logic [6:0] model_seg(input int cnt, input int idx);
        int digit;
        digit = (idx == 0) ? (cnt % 10) : (cnt / 10);
`ifdef CLOCK_SCAN_LZB_EN
        if (idx != 0 && cnt < 10) return 7'b0000000;
`endif
        return seg_tab[digit];
    endfunction

    task automatic model_reset();
        m_count = 0;
        m_presc = 0;
        m_scan  = 0;
        m_idx   = 0;
        m_wrap  = 1'b0;
    endtask

    // One clock: display outputs reflect pre-edge state, counter state updates.
    task automatic step(input logic r, input logic c);
        logic [1:0] e_bit;
        logic [6:0] e_seg;
        run   = r;
        clear = c;
        e_bit = (m_idx == 0) ? 2'b01 : 2'b10;
        e_seg = model_seg(m_count, m_idx);
        if (c) begin
            m_count = 0;
            m_presc = 0;
            m_wrap  = 1'b0;
        end else if (r) begin
            if (m_presc == TICK_DIV - 1) begin
                m_wrap  = (m_count == 99);
                m_count = (m_count + 1) % 100;
                m_presc = 0;
            end else begin
                m_presc++;
                m_wrap = 1'b0;
            end
        end else begin
            m_wrap = 1'b0;
        end
        m_scan++;
        if (m_scan == SCAN_DIV) begin
            m_scan = 0;
            m_idx  = (m_idx + 1) % DIGITS;
        end
        @(posedge clk);
        #1;
        check("count_bcd", count_bcd, exp_bcd(m_count));
        check("wrap", wrap, m_wrap);
        check("sm_bit", sm_bit, e_bit);
        check("sm_seg", sm_seg, e_seg);
    endtask

    // Asynchronous reset between edges; outputs must clear without a clock.
    task automatic apply_reset();
        #2;
        rst = 1'b1;
        model_reset();
        #1;
        check("rst_sm_bit", sm_bit, 2'b00);
        check("rst_sm_seg", sm_seg, 7'b0000000);
        check("rst_count", count_bcd, 8'h00);
        check("rst_wrap", wrap, 1'b0);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        int n;
        seg_tab[0] = 7'b1111110; seg_tab[1] = 7'b0110000;
        seg_tab[2] = 7'b1101101; seg_tab[3] = 7'b1111001;
        seg_tab[4] = 7'b0110011; seg_tab[5] = 7'b1011011;
        seg_tab[6] = 7'b1011111; seg_tab[7] = 7'b1110000;
        seg_tab[8] = 7'b1111111; seg_tab[9] = 7'b1111011;

        // run 10, hold 3 (prescaler parked at 2), resume: tick on 2nd cycle
        vecs[0]  = '{1'b1, 1'b0, 8'h00, 1'b0};
        vecs[1]  = '{1'b1, 1'b0, 8'h00, 1'b0};
        vecs[2]  = '{1'b1, 1'b0, 8'h00, 1'b0};
        vecs[3]  = '{1'b1, 1'b0, 8'h01, 1'b0};
        vecs[4]  = '{1'b1, 1'b0, 8'h01, 1'b0};
        vecs[5]  = '{1'b1, 1'b0, 8'h01, 1'b0};
        vecs[6]  = '{1'b1, 1'b0, 8'h01, 1'b0};
        vecs[7]  = '{1'b1, 1'b0, 8'h02, 1'b0};
        vecs[8]  = '{1'b1, 1'b0, 8'h02, 1'b0};
        vecs[9]  = '{1'b1, 1'b0, 8'h02, 1'b0};
        vecs[10] = '{1'b0, 1'b0, 8'h02, 1'b0};
        vecs[11] = '{1'b0, 1'b0, 8'h02, 1'b0};
        vecs[12] = '{1'b0, 1'b0, 8'h02, 1'b0};
        vecs[13] = '{1'b1, 1'b0, 8'h02, 1'b0};
        vecs[14] = '{1'b1, 1'b0, 8'h03, 1'b0};

        // Power-on reset
        rst = 1'b1; run = 1'b0; clear = 1'b0;
        model_reset();
        #2;
        check("por_sm_bit", sm_bit, 2'b00);
        check("por_sm_seg", sm_seg, 7'b0000000);
        check("por_count", count_bcd, 8'h00);
        @(negedge clk);
        rst = 1'b0;

        // Idle scan: first edge shows digit 0 as '0', then alternates every 2
        step(1'b0, 1'b0);
        check("first_sm_bit", sm_bit, 2'b01);
        check("first_sm_seg", sm_seg, 7'b1111110);
        for (int i = 0; i < 9; i++) step(1'b0, 1'b0);

        // Table: tick cadence and prescaler hold
        apply_reset();
        for (int i = 0; i < 15; i++) begin
            step(vecs[i].run, vecs[i].clear);
            check("vec_count", count_bcd, vecs[i].exp_count);
            check("vec_wrap", wrap, vecs[i].exp_wrap);
        end

        // Rollover 99 -> 00 with single-cycle wrap
        apply_reset();
        n = 0;
        while (!(m_count == 99 && m_presc == TICK_DIV - 1) && n < 500) begin
            step(1'b1, 1'b0);
            n++;
        end
        check("reach_99", (m_count == 99) ? 1 : 0, 1);
        step(1'b1, 1'b0);
        check("roll_count", count_bcd, 8'h00);
        check("roll_wrap", wrap, 1'b1);
        step(1'b1, 1'b0);
        check("roll_wrap_drop", wrap, 1'b0);

        // Clear on the tick cycle at 37
        apply_reset();
        n = 0;
        while (!(m_count == 37 && m_presc == TICK_DIV - 1) && n < 300) begin
            step(1'b1, 1'b0);
            n++;
        end
        check("reach_37", (m_count == 37) ? 1 : 0, 1);
        step(1'b1, 1'b1);
        check("clr_count", count_bcd, 8'h00);
        check("clr_wrap", wrap, 1'b0);
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 1'b0);
            check("clr_hold", count_bcd, 8'h00);
        end
        step(1'b1, 1'b0);
        check("clr_next_tick", count_bcd, 8'h01);

        // Count 05: digit 1 display (blank with macro, '0' without)
        apply_reset();
        n = 0;
        while (m_count != 5 && n < 100) begin
            step(1'b1, 1'b0);
            n++;
        end
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 1'b0);
            if (sm_bit == 2'b10) begin
`ifdef CLOCK_SCAN_LZB_EN
                check("d1_of_05", sm_seg, 7'b0000000);
`else
                check("d1_of_05", sm_seg, 7'b1111110);
`endif
            end else begin
                check("d0_of_05", sm_seg, 7'b1011011);
            end
        end

        // Async reset at 42 mid-cycle
        n = 0;
        while (m_count != 42 && n < 300) begin
            step(1'b1, 1'b0);
            n++;
        end
        check("reach_42", count_bcd, 8'h42);
        apply_reset();
        step(1'b0, 1'b0);
        check("post_rst_bit", sm_bit, 2'b01);
        check("post_rst_seg", sm_seg, 7'b1111110);

        // Random run/clear against the model
        for (int i = 0; i < 600; i++) begin
            step(($urandom_range(0, 3) != 0) ? 1'b1 : 1'b0,
                 ($urandom_range(0, 40) == 0) ? 1'b1 : 1'b0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/clock_scan.md
CLOCK_SCAN -- requirements
Module: clock_scan

Interface
REQ-001 The module SHALL have parameter DIGITS, default 4, meaning the number of BCD digits counted and scanned (legal 1..8).
REQ-002 The module SHALL have parameter TICK_DIV, default 1000, meaning the clk cycles per count increment while running (legal >=1).
REQ-003 The module SHALL have parameter SCAN_DIV, default 100, meaning the clk cycles per digit-scan step (legal >=1).
REQ-004 The module SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-005 The module SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-006 The module SHALL have port run, input, 1 bit: count enable; when low, the count and prescaler hold.
REQ-007 The module SHALL have port clear, input, 1 bit: synchronous clear of the count and prescaler.
REQ-008 The module SHALL have port sm_bit, output, DIGITS bits: one-hot, active-high digit select; bit 0 is the least significant digit.
REQ-009 The module SHALL have port sm_seg, output, 7 bits: active-high segments {a,b,c,d,e,f,g}, with a as the MSB.
REQ-010 The module SHALL have port count_bcd, output, 4*DIGITS bits: the packed BCD count, with digit 0 in bits [3:0].
REQ-011 The module SHALL have port wrap, output, 1 bit: a one-cycle pulse on rollover from all-9s to all-0s.

Function
REQ-012 The prescaler SHALL count 0..TICK_DIV-1 on each clk with run=1 and clear=0, return to 0 after TICK_DIV-1, and hold when run=0.
REQ-013 A tick SHALL occur on the edge where the prescaler equals TICK_DIV-1 and run=1; count_bcd SHALL update on that same edge (latency 1 clk from the qualifying cycle).
REQ-014 On a tick, count_bcd SHALL increment by one in decimal: a digit at 9 becomes 0 and carries into the next digit, and no digit ever holds a value 10..15.
REQ-015 On a tick with all digits at 9, count_bcd SHALL become all 0 and wrap SHALL be 1 for exactly that one following cycle; otherwise wrap=0.
REQ-016 clear=1 SHALL set count_bcd and the prescaler to 0 on the next edge, override run, suppress any tick and wrap that cycle, and leave scanning unaffected.
REQ-017 With TICK_DIV=1, every cycle with run=1 SHALL be a tick.
REQ-018 The scan counter SHALL count 0..SCAN_DIV-1 freely, regardless of run and clear; on reaching SCAN_DIV-1 it SHALL return to 0 and advance the digit index (0..DIGITS-1, then wrap to 0).
REQ-019 Every edge SHALL register sm_bit = one-hot(digit index) and sm_seg = decode(selected digit of the current count_bcd), so that sm_bit and sm_seg are always mutually aligned.
REQ-020 The decode SHALL be: 0=1111110, 1=0110000, 2=1101101, 3=1111001, 4=0110011, 5=1011011, 6=1011111, 7=1110000, 8=1111111, 9=1111011; any other code decodes to 0000000.
REQ-021 With DIGITS=1, sm_bit SHALL remain 1 continuously after its first post-reset edge.

Reset
REQ-022 While rst=1, the prescaler, scan counter, digit index, count_bcd, and wrap SHALL be 0, sm_bit SHALL be all 0, and sm_seg SHALL be 0000000, regardless of clk.
REQ-023 On the first rising clk after rst falls, sm_bit SHALL become ...0001 and sm_seg SHALL become 1111110.
REQ-024 Asserting rst mid-count or mid-scan SHALL abandon all state immediately, with no pending tick or wrap surviving.

Configuration
REQ-025 With macro CLOCK_SCAN_LZB_EN defined, leading-zero blanking SHALL apply: any digit above the most significant nonzero digit drives sm_seg=0000000 while selected, digit 0 is always displayed, and sm_bit scanning is unchanged.
REQ-026 Without CLOCK_SCAN_LZB_EN, all digits SHALL be decoded per REQ-020, leading zeros included; count_bcd and wrap behave identically in both builds.

Verification (DIGITS=2, TICK_DIV=4, SCAN_DIV=2 unless noted)
REQ-027 Reset release, run=0, 10 clks -> count_bcd=0x00; sm_bit alternates 01,10 every 2 clks; sm_seg=1111110 throughout (no macro).
REQ-028 run=1 for 8 clks from reset -> count_bcd=0x01 after clk 4 and 0x02 after clk 8; drop run at clk 9 -> count_bcd holds 0x02 and the prescaler holds.
REQ-029 Preload by running to 0x99, then tick -> count_bcd=0x00 with wrap=1 for exactly one clk.
REQ-030 run=1 and clear=1 on the cycle where prescaler=3 with count=0x37 -> next edge count_bcd=0x00, wrap=0, and the next tick occurs 4 clks after clear drops.
REQ-031 Count=0x05 with the macro defined -> selected digit 1 shows 0000000 and digit 0 shows 1011011; without the macro, digit 1 shows 1111110.
REQ-032 rst pulsed asynchronously between edges at count=0x42 -> all outputs are 0 immediately; first clk after release -> sm_bit=01, sm_seg=1111110.
